divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width.
REQ-002 Parameter: DIVU, 6'b011011, unsigned-divide start code on Signal.
REQ-003 Parameter: OUT, 6'b111111, result-to-HILO transfer code on Signal.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dataA  input  32  dividend, sampled only at start.
REQ-007 dataB  input  32  divisor, sampled only at start.
REQ-008 Signal  input  6  command from control unit (DIVU, OUT, other = no-op).
REQ-009 dataOut  output  64  {remainder[63:32], quotient[31:0]}, i.e. {HI, LO}.
REQ-010 busy  output  1  high while iterating.
REQ-011 done  output  1  high while a valid result is held, awaiting OUT.
REQ-012 div_by_zero  output  1  last started operation had divisor 0.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-014 Internal state: 64-bit working register R, 32-bit divisor register D, 5-bit step counter.
REQ-015 IDLE or DONE, Signal==DIVU at edge N, dataB!=0: R<={32'b0,dataA}, D<=dataB, counter<=0, div_by_zero<=0, state<=RUN.
REQ-016 RUN, each edge: T={R[62:0],1'b0}; if T[63:32]>=D then R<={T[63:32]-D, T[31:1], 1'b1} else R<=T; counter++.
REQ-017 Comparison and subtraction SHALL be 32-bit unsigned; carry out discarded.
REQ-018 RUN SHALL perform exactly 32 steps at edges N+1..N+32; at edge N+32 state<=DONE.
REQ-019 Latency: done first high after edge N+32; R then holds {remainder, quotient}.
REQ-020 Signal==DIVU or OUT during RUN SHALL be ignored; operation continues undisturbed.
REQ-021 DONE, Signal==OUT: dataOut<=R, state<=IDLE.
REQ-022 IDLE, Signal==OUT: dataOut<=R (re-reads last result); state stays IDLE.
REQ-023 DONE, Signal==DIVU: new operation starts per REQ-015; unread result discarded.
REQ-024 Any other Signal value: state, R, dataOut unchanged.
REQ-025 dataOut SHALL change only on OUT or reset.
REQ-026 Divide by zero at start: R<={dataA, 32'hFFFFFFFF}, div_by_zero<=1, state<=DONE at edge N (no RUN).
REQ-027 div_by_zero SHALL hold until next DIVU start or reset.

Reset
REQ-028 reset high at edge: state<=IDLE, R<=0, D<=0, counter<=0, dataOut<=0, div_by_zero<=0; busy=done=0.
REQ-029 reset SHALL take priority over Signal; reset mid-RUN aborts, no partial result visible.

Structure
REQ-030 Shared package holds WIDTH, DIVU, OUT codes (alongside MULTU) and the state enum.
REQ-031 One combinational sub-module, div_step, SHALL implement REQ-016 for one iteration.
REQ-032 No other sub-modules; single always block for FSM plus registers.

Verification
REQ-033 100/7: DIVU at N, OUT after done -> dataOut=64'h00000002_0000000E; done first high after N+32.
REQ-034 32'hFFFFFFFF/1 -> dataOut=64'h00000000_FFFFFFFF, div_by_zero=0.
REQ-035 5/0 -> done after edge N, dataOut=64'h00000005_FFFFFFFF after OUT, div_by_zero=1.
REQ-036 3/10 -> dataOut=64'h00000003_00000000.
REQ-037 DIVU 100/7 then DIVU 9/2 at step 10 -> ignored, result still {2,14}.
REQ-038 reset at step 10 -> next cycle busy=0, done=0, dataOut=0; subsequent OUT gives 0.

Source files
------------

// File: rtl/divider_unit_pkg.sv
// Shared command codes, operand width and divider FSM state encoding.
// Pure declarations; no latency or flow control of its own.
package divider_unit_pkg;

   localparam int unsigned DIV_WIDTH  = 32;
   localparam logic [5:0]  MULTU_CODE = 6'b011001;
   localparam logic [5:0]  DIVU_CODE  = 6'b011011;
   localparam logic [5:0]  OUT_CODE   = 6'b111111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider_unit_step.sv
// One restoring shift-subtract iteration on the {remainder, quotient} register.
// Purely combinational; no flow control.
module div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] r,
   input  logic [WIDTH-1:0]   d,
   output logic [2*WIDTH-1:0] r_next
);

   logic [WIDTH-1:0] hi;
   logic             unused_shift_out;

   // The MSB shifted out of the remainder half is dropped; compare is plain 32-bit.
   assign hi               = r[2*WIDTH-2:WIDTH-1];
   assign unused_shift_out = r[2*WIDTH-1];

   always_comb begin
      r_next = {hi, r[WIDTH-2:0], 1'b0};
      if (hi >= d) begin
         r_next = {hi - d, r[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divider_unit.sv
// Iterative unsigned divider: DIVU starts, OUT copies {remainder, quotient} to dataOut.
// 32 cycles from start to done (divide-by-zero finishes at the start edge); commands during RUN are ignored.
module divider_unit
   import divider_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter logic [5:0]  DIVU  = DIVU_CODE,
   parameter logic [5:0]  OUT   = OUT_CODE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   dataA,
   input  logic [WIDTH-1:0]   dataB,
   input  logic [5:0]         Signal,
   output logic [2*WIDTH-1:0] dataOut,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state;
   logic [2*WIDTH-1:0] r;
   logic [2*WIDTH-1:0] r_next;
   logic [WIDTH-1:0]   d;
   logic [CNT_W-1:0]   cnt;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .d      (d),
      .r_next (r_next)
   );

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         r           <= '0;
         d           <= '0;
         cnt         <= '0;
         dataOut     <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Signal == DIVU) begin
                  d   <= dataB;
                  cnt <= '0;
                  if (dataB == '0) begin
                     // Zero divisor: quotient saturates, dividend left in the remainder half.
                     r           <= {dataA, {WIDTH{1'b1}}};
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     r           <= {{WIDTH{1'b0}}, dataA};
                     div_by_zero <= 1'b0;
                     state       <= RUN;
                  end
               end else if (Signal == OUT) begin
                  dataOut <= r;
                  state   <= IDLE;
               end
            end
            RUN: begin
               r   <= r_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// Directed plus randomized checks of divider_unit against plain-arithmetic division.
module tb_divider_unit;

   localparam logic [5:0] C_DIVU = 6'b011011;
   localparam logic [5:0] C_OUT  = 6'b111111;
   localparam logic [5:0] C_NOP  = 6'b000000;

   logic        clk;
   logic        reset;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  Signal;
   logic [63:0] dataOut;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   int          total;
   int          passed;
   int          failed;
   logic [63:0] last_out;

   divider_unit dut (
      .clk         (clk),
      .reset       (reset),
      .dataA       (dataA),
      .dataB       (dataB),
      .Signal      (Signal),
      .dataOut     (dataOut),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply a command for exactly one rising edge, then return to a no-op at the falling edge.
   task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
      Signal = sig;
      dataA  = a;
      dataB  = b;
      @(posedge clk);
      @(negedge clk);
      Signal = C_NOP;
   endtask

   // Counts edges after the start edge until done is seen; 41 means it never came.
   task automatic wait_done(output int k);
      k = 41;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] exp;
      logic        zero;
      int          k;
      zero = (b == 32'd0);
      exp  = zero ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      issue(C_DIVU, a, b);
      check({tag, "_busy"}, busy, !zero);
      check({tag, "_dbz"}, div_by_zero, zero);
      if (!zero) begin
         wait_done(k);
         check({tag, "_latency"}, k, 32);
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_hold"}, dataOut, last_out);
      issue(C_OUT, 32'd0, 32'd0);
      check({tag, "_result"}, dataOut, exp);
      check({tag, "_idle"}, {busy, done}, 2'b00);
      check({tag, "_dbz_kept"}, div_by_zero, zero);
      last_out = exp;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          k;
      total    = 0;
      passed   = 0;
      failed   = 0;
      last_out = 64'd0;
      reset    = 1'b1;
      Signal   = C_NOP;
      dataA    = 32'd0;
      dataB    = 32'd0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("reset_out", dataOut, 64'd0);
      check("reset_flags", {busy, done, div_by_zero}, 3'b000);
      reset = 1'b0;
      @(negedge clk);

      run_div(32'd100, 32'd7, "d100_7");
      run_div(32'hFFFF_FFFF, 32'd1, "dmax_1");
      run_div(32'd5, 32'd0, "d5_0");
      run_div(32'd3, 32'd10, "d3_10");

      // OUT while idle re-reads the last result; other codes change nothing.
      issue(C_OUT, 32'd0, 32'd0);
      check("reread", dataOut, 64'h0000_0003_0000_0000);
      issue(6'b011001, 32'd77, 32'd3);
      check("other_code", {dataOut, busy, done}, {64'h0000_0003_0000_0000, 2'b00});

      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : ($urandom & 32'h7FFF_FFFF);
         if (i == 7) rb = 32'd0;
         else if (rb == 32'd0) rb = 32'd1;
         run_div(ra, rb, $sformatf("rand%0d", i));
      end

      // Commands during RUN are ignored.
      issue(C_DIVU, 32'd100, 32'd7);
      k = 41;
      for (int i = 1; i <= 40; i++) begin
         if (i == 10) begin
            Signal = C_DIVU;
            dataA  = 32'd9;
            dataB  = 32'd2;
         end else if (i == 12) begin
            Signal = C_OUT;
         end else begin
            Signal = C_NOP;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            k = i;
            break;
         end
      end
      Signal = C_NOP;
      check("ignore_latency", k, 32);
      check("ignore_hold", dataOut, last_out);
      issue(C_OUT, 32'd0, 32'd0);
      check("ignore_result", dataOut, 64'h0000_0002_0000_000E);
      last_out = dataOut;

      // A new DIVU in DONE discards the unread result.
      issue(C_DIVU, 32'd50, 32'd3);
      wait_done(k);
      check("discard_first_done", k, 32);
      issue(C_DIVU, 32'd20, 32'd6);
      check("discard_restart_busy", {busy, done}, 2'b10);
      wait_done(k);
      check("discard_second_done", k, 32);
      issue(C_OUT, 32'd0, 32'd0);
      check("discard_result", dataOut, 64'h0000_0002_0000_0003);

      // Reset mid-RUN aborts with nothing visible.
      issue(C_DIVU, 32'd5, 32'd0);
      issue(C_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_flags", {busy, done, div_by_zero}, 3'b000);
      check("abort_out", dataOut, 64'd0);
      issue(C_OUT, 32'd0, 32'd0);
      check("abort_reread", dataOut, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
